// File: rtl/control_pkg.sv
// control_pkg
//   Shared definitions for the control state-register next-state logic:
//   debounce FSM encoding and the default debounce length.
//   DEBOUNCE_CYCLES_DEF : consecutive stable cycles (10 ms @ 50 MHz)
//   CNT_W_DEF           : counter width, 2**CNT_W_DEF > DEBOUNCE_CYCLES_DEF
package control_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned CNT_W_DEF           = 20;

   // 2'd3 is unused; the FSM recovers from it to ST_REL_WAIT.
   typedef enum logic [1:0] {
      ST_REL_WAIT = 2'd0,
      ST_IDLE     = 2'd1,
      ST_PRESS_DB = 2'd2
   } db_state_e;

endpackage

// File: rtl/control_debounce.sv
// control_debounce
//   Two-flop synchroniser, saturating debounce counter and press/release FSM
//   for a raw pushbutton.
//   clk_i      : clock, rising edge
//   reset_i    : synchronous active-high reset
//   btn_raw_i  : asynchronous bouncing button, 1 = pressed
//   press_ok_o : combinational strobe, high in the cycle whose edge accepts a press
//   busy_o     : 1 whenever the FSM is not in IDLE (decoded from the state register)
module control_debounce
   import control_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_raw_i,
   output logic press_ok_o,
   output logic busy_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             btn_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   db_state_e        state_q, state_d;

   // Synchroniser and state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_q    <= 1'b0;
         btn_s_q <= 1'b0;
         cnt_q   <= '0;
         state_q <= ST_REL_WAIT;
      end else begin
         s1_q    <= btn_raw_i;
         btn_s_q <= s1_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   // Next-state logic. The counter saturates instead of wrapping; it is only
   // ever compared against CNT_LAST.
   always_comb begin
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_REL_WAIT: begin
            if (btn_s_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_IDLE: begin
            if (btn_s_q) begin
               state_d = ST_PRESS_DB;
               cnt_d   = '0;
            end
         end
         ST_PRESS_DB: begin
            if (!btn_s_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_REL_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_REL_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      busy_o     = (state_q != ST_IDLE);
      press_ok_o = (state_q == ST_PRESS_DB) && btn_s_q && (cnt_q == CNT_LAST);
   end

endmodule

// File: rtl/control_next_state.sv
// control_next_state
//   Next-state (NS) input of the 1-bit control state register. Each debounced
//   press toggles the stored state once; holding the button toggles only once.
//   clk_main     : clock, rising edge
//   reset        : synchronous active-high reset
//   btn_raw      : asynchronous bouncing pushbutton, 1 = pressed
//   en           : 1 = accepted presses toggle, 0 = presses consumed silently
//   cur_state    : state register output (fed back, not registered here)
//   NS           : cur_state ^ toggle_pulse
//   toggle_pulse : registered one-cycle strobe per accepted press
//   busy         : 1 while the debounce FSM is not IDLE
module control_next_state
   import control_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk_main,
   input  logic reset,
   input  logic btn_raw,
   input  logic en,
   input  logic cur_state,
   output logic NS,
   output logic toggle_pulse,
   output logic busy
);

   logic press_ok;
   logic toggle_pulse_q;

   control_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk_i      (clk_main),
      .reset_i    (reset),
      .btn_raw_i  (btn_raw),
      .press_ok_o (press_ok),
      .busy_o     (busy)
   );

   // en is only looked at on the accepting edge, so a disabled press is
   // consumed rather than deferred.
   always_ff @(posedge clk_main) begin
      if (reset) begin
         toggle_pulse_q <= 1'b0;
      end else begin
         toggle_pulse_q <= press_ok & en;
      end
   end

   assign toggle_pulse = toggle_pulse_q;
   assign NS           = cur_state ^ toggle_pulse_q;

endmodule

// File: tb/tb_control_next_state.sv
module tb_control_next_state;

   localparam int DC = 4;

   logic clk = 1'b0;
   logic reset, btn_raw, en, cur_state;
   logic NS, toggle_pulse, busy;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   control_next_state #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (3)
   ) dut (
      .clk_main     (clk),
      .reset        (reset),
      .btn_raw      (btn_raw),
      .en           (en),
      .cur_state    (cur_state),
      .NS           (NS),
      .toggle_pulse (toggle_pulse),
      .busy         (busy)
   );

   // The 1-bit state register closing the loop.
   always @(posedge clk) begin
      if (reset) cur_state <= 1'b0;
      else       cur_state <= NS;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Run-length reference: the FSM sees the button two edges late; after a
   // pulse (or reset) DC consecutive released samples arm it, and while armed
   // DC+1 consecutive pressed samples fire one pulse (gated by en).
   bit m_sh1, m_sh2, m_armed, m_pulse, m_busy, m_cur, m_valid;
   int m_zrun, m_orun;

   always @(posedge clk) begin
      bit bs;
      if (reset) begin
         m_sh1 = 0; m_sh2 = 0; m_armed = 0; m_zrun = 0; m_orun = 0;
         m_cur = 0; m_pulse = 0;
      end else begin
         bs    = m_sh2;
         m_sh2 = m_sh1;
         m_sh1 = btn_raw;
         m_cur = m_cur ^ m_pulse;
         m_pulse = 0;
         if (!m_armed) begin
            m_zrun = bs ? 0 : m_zrun + 1;
            if (m_zrun >= DC) begin
               m_armed = 1;
               m_orun  = 0;
            end
         end else if (bs) begin
            m_orun++;
            if (m_orun == DC + 1) begin
               m_pulse = en;
               m_armed = 0;
               m_zrun  = 0;
               m_orun  = 0;
            end
         end else begin
            m_orun = 0;
         end
      end
      m_busy  = !(m_armed && m_orun == 0);
      m_valid = 1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("toggle_pulse", toggle_pulse, m_pulse);
         chk("busy", busy, m_busy);
         chk("NS", NS, m_cur ^ m_pulse);
         chk("cur_state", cur_state, m_cur);
      end
      if (toggle_pulse === 1'b1) pulses++;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press(input int hold, input int rel);
      btn_raw = 1'b1;
      cyc(hold);
      btn_raw = 1'b0;
      cyc(rel);
   endtask

   initial begin
      int p0, first, lat;
      reset = 1'b1; btn_raw = 1'b0; en = 1'b1;

      // 1: reset state, then busy clears after DC released edges
      cyc(3);
      chk("rst_pulse", toggle_pulse, 0);
      chk("rst_NS", NS, 0);
      chk("rst_busy", busy, 1);
      reset = 1'b0;
      first = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (!busy && first == 0) first = i;
      end
      #1;
      chk("busy_release_cycles", first, 4);

      // 2: clean press, pulse 7 cycles after the rise
      p0 = pulses;
      btn_raw = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (toggle_pulse && lat == 0) lat = i;
      end
      #1;
      btn_raw = 1'b0;
      cyc(10);
      chk("press_latency", lat, 7);
      chk("press_count", pulses - p0, 1);
      chk("press_state", cur_state, 1);

      // 3: bounce rejected
      p0 = pulses;
      btn_raw = 1'b1; cyc(1);
      btn_raw = 1'b0; cyc(1);
      btn_raw = 1'b1; cyc(1);
      btn_raw = 1'b0; cyc(10);
      chk("bounce_count", pulses - p0, 0);
      chk("bounce_idle", busy, 0);
      chk("bounce_state", cur_state, 1);

      // 4: two presses, then a long hold
      p0 = pulses;
      press(20, 10);
      press(20, 10);
      chk("two_press_count", pulses - p0, 2);
      chk("two_press_state", cur_state, 1);
      p0 = pulses;
      press(50, 10);
      chk("long_hold_count", pulses - p0, 1);
      chk("long_hold_state", cur_state, 0);

      // 5: en=0 consumes the press; enabling while held does not revive it
      p0 = pulses;
      en = 1'b0;
      btn_raw = 1'b1;
      cyc(20);
      chk("en0_count", pulses - p0, 0);
      chk("en0_ns", NS, cur_state);
      en = 1'b1;
      cyc(20);
      chk("en1_held_count", pulses - p0, 0);
      btn_raw = 1'b0;
      cyc(10);
      press(20, 10);
      chk("en1_repress_count", pulses - p0, 1);
      chk("en1_state", cur_state, 1);

      // 6: reset mid-debounce, button held across reset release
      p0 = pulses;
      btn_raw = 1'b1;
      cyc(5);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(20);
      chk("rst_mid_count", pulses - p0, 0);
      btn_raw = 1'b0;
      cyc(3);
      press(20, 10);
      chk("short_release_count", pulses - p0, 0);
      press(20, 10);
      chk("after_release_count", pulses - p0, 1);
      chk("after_release_state", cur_state, 1);

      // 7: reset in the same cycle as the pulse wins
      btn_raw = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (toggle_pulse) lat = i;
      end
      #1;
      chk("coincide_seen", lat, 7);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("coincide_pulse", toggle_pulse, 0);
      chk("coincide_state", cur_state, 0);
      btn_raw = 1'b0;
      cyc(10);

      // Randomised phase
      for (int k = 0; k < 300; k++) begin
         btn_raw = 1'($urandom_range(0, 1));
         en      = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
         end
         cyc($urandom_range(1, 12));
      end
      btn_raw = 1'b0;
      cyc(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
